// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 stream demultiplexer.
// Optional per-channel delivery counters are enabled by DEMUX_COUNT_EN.
package demux_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_sel_t;
    typedef logic [7:0] beat_cnt_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// With DEMUX_COUNT_EN defined it also counts delivered beats.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic             free
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]       count
`endif
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             drain;

    assign drain = valid_q && ready;
    assign free  = !valid_q || ready;
    assign valid = valid_q;
    assign q     = data_q;

    // Load wins over drain so a same-cycle refill leaves no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_COUNT_EN
    beat_cnt_t count_q;
    beat_cnt_t count_d;

    // Count output transfers; natural 8-bit wrap.
    always_comb begin
        count_d = count_q;
        if (drain) begin
            count_d = count_q + beat_cnt_t'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demux; one output slot per channel.
// Port out_count exists only when DEMUX_COUNT_EN is defined.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [WIDTH-1:0]      in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*WIDTH-1:0]    out_data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [4*8-1:0]        out_count
`endif
);

    ch_sel_t         sel;
    logic [N_CH-1:0] free;
    logic [N_CH-1:0] load;
    logic            xfer;

    assign sel      = in_sel;
    assign in_ready = free[sel];
    assign xfer     = in_valid && in_ready;

    // Decode the selected slot for loading on an input transfer.
    always_comb begin
        load = '0;
        unique case (sel)
            2'd0: load[0] = xfer;
            2'd1: load[1] = xfer;
            2'd2: load[2] = xfer;
            2'd3: load[3] = xfer;
            default: load = '0;
        endcase
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .d     (in_data),
            .ready (out_ready[i]),
            .valid (out_valid[i]),
            .q     (out_data[i*WIDTH +: WIDTH]),
            .free  (free[i])
`ifdef DEMUX_COUNT_EN
            ,
            .count (out_count[i*8 +: 8])
`endif
        );
    end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed and random self-checking bench for demux_1_4_stream.
// Counter checks are built only when DEMUX_COUNT_EN is defined.
module tb_demux_1_4_stream;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
`ifdef DEMUX_COUNT_EN
    logic [31:0]    out_count;
`endif

    int n_checks;
    int n_fail;

    demux_1_4_stream #(.WIDTH(W)) dut (
`ifdef DEMUX_COUNT_EN
        .out_count (out_count),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'h9;
        out_ready = 4'b0000;
        repeat (3) step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ignore_in got=%b exp=0000", out_valid);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0000", out_valid);
        end
        n_checks++;
        if (out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0000", out_data);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_routing();
        logic [W-1:0] exp_d;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_d    = W'(4'ha + k);
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = exp_d;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL route_ready ch%0d got=%b exp=1", k, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 4'(1 << k)) begin
                n_fail++;
                $display("FAIL route_valid ch%0d got=%b exp=%b",
                         k, out_valid, 4'(1 << k));
            end
            n_checks++;
            if (out_data[k*W +: W] !== exp_d) begin
                n_fail++;
                $display("FAIL route_data ch%0d got=%h exp=%h",
                         k, out_data[k*W +: W], exp_d);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL route_clear got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 4'h5;
        step();
        n_checks++;
        if (out_valid !== 4'b0100 || out_data[8 +: 4] !== 4'h5) begin
            n_fail++;
            $display("FAIL bp_load got=%b/%h exp=0100/5",
                     out_valid, out_data[8 +: 4]);
        end
        in_data = 4'h6;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_block got=%b exp=0", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0100 || out_data[8 +: 4] !== 4'h5) begin
            n_fail++;
            $display("FAIL bp_hold got=%b/%h exp=0100/5",
                     out_valid, out_data[8 +: 4]);
        end
        in_sel  = 2'd0;
        in_data = 4'h7;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_other_ready got=%b exp=1", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0101 || out_data[0 +: 4] !== 4'h7) begin
            n_fail++;
            $display("FAIL bp_other got=%b/%h exp=0101/7",
                     out_valid, out_data[0 +: 4]);
        end
        in_sel    = 2'd2;
        in_data   = 4'h6;
        out_ready = 4'b0100;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_data[8 +: 4] !== 4'h5) begin
            n_fail++;
            $display("FAIL bp_release got=%b/%h exp=1/5",
                     in_ready, out_data[8 +: 4]);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0101 || out_data[8 +: 4] !== 4'h6) begin
            n_fail++;
            $display("FAIL bp_second got=%b/%h exp=0101/6",
                     out_valid, out_data[8 +: 4]);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0001 || out_data[0 +: 4] !== 4'h7) begin
            n_fail++;
            $display("FAIL bp_drain got=%b/%h exp=0001/7",
                     out_valid, out_data[0 +: 4]);
        end
        out_ready = 4'b1111;
        step();
        n_checks++;
        if (out_valid !== 4'b0000 || out_data[8 +: 4] !== 4'h6) begin
            n_fail++;
            $display("FAIL bp_empty got=%b/%h exp=0000/6",
                     out_valid, out_data[8 +: 4]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b1000;
        in_sel    = 2'd3;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready beat%0d got=%b exp=1", i, in_ready);
            end
            step();
            n_checks++;
            if (out_valid[3] !== 1'b1 || out_data[12 +: 4] !== W'(i)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h",
                         i, out_valid[3], out_data[12 +: 4], W'(i));
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_end got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   q[4][$];
        logic [W-1:0]   exp_d;
        logic [3:0]     pv;
        logic [3:0]     pr;
        logic [4*W-1:0] pd;
        logic           prev_rdy;
        pv       = 4'b0000;
        pr       = 4'b0000;
        pd       = '0;
        prev_rdy = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 2010; c++) begin
            @(negedge clk);
            if (c >= 2000) begin
                in_valid  = 1'b0;
                out_ready = 4'b1111;
            end else begin
                if (!(in_valid && !prev_rdy)) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_sel   = 2'($urandom_range(0, 3));
                    in_data  = W'($urandom);
                end
                out_ready = 4'($urandom);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr[i]) begin
                    n_checks++;
                    if (out_valid[i] !== 1'b1 ||
                        out_data[i*W +: W] !== pd[i*W +: W]) begin
                        n_fail++;
                        $display("FAIL rnd_stable c%0d ch%0d got=%b/%h exp=1/%h",
                                 c, i, out_valid[i], out_data[i*W +: W],
                                 pd[i*W +: W]);
                    end
                end
                n_checks++;
                if (q[i].size() !== int'(out_valid[i])) begin
                    n_fail++;
                    $display("FAIL rnd_occupancy c%0d ch%0d got=%b exp_size=%0d",
                             c, i, out_valid[i], q[i].size());
                end
                if (out_valid[i] && out_ready[i] && q[i].size() > 0) begin
                    exp_d = q[i].pop_front();
                    n_checks++;
                    if (out_data[i*W +: W] !== exp_d) begin
                        n_fail++;
                        $display("FAIL rnd_data c%0d ch%0d got=%h exp=%h",
                                 c, i, out_data[i*W +: W], exp_d);
                    end
                end
            end
            if (in_valid && in_ready) q[in_sel].push_back(in_data);
            prev_rdy = in_ready;
            pv       = out_valid;
            pr       = out_ready;
            pd       = out_data;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q[i].size() != 0 || out_valid[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_final ch%0d got_size=%0d exp=0",
                         i, q[i].size());
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = W'(k + 1);
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b1111 || out_data !== 16'h4321) begin
            n_fail++;
            $display("FAIL mid_fill got=%b/%h exp=1111/4321",
                     out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset got=%b/%h exp=0000/0000",
                     out_valid, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_release got=%b/%b exp=1/0000",
                     in_ready, out_valid);
        end
    endtask

`ifdef DEMUX_COUNT_EN
    task automatic test_count();
        n_checks++;
        if (out_count !== 32'h0) begin
            n_fail++;
            $display("FAIL cnt_reset got=%h exp=00000000", out_count);
        end
        out_ready = 4'b1111;
        in_sel    = 2'd1;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_count !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL cnt_wrap got=%h exp=00000100", out_count);
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef DEMUX_COUNT_EN
        test_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
